// File: rtl/dmem_arb_pkg.sv
// Shared types for the dmem_arbiter slice: access-size codes, FSM states, byte-count helper.
// No logic of its own; imported by the arbiter, its request checker and the port interface users.
// Size encoding 2'b11 is reserved and always rejected by the checker.
package dmem_arb_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Number of bytes touched by an access of the given size (reserved code reports 4).
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for both requester ports plus the data_memory command port.
// 'slave' is the arbiter's view; 'master' is the surrounding system (requesters and memory).
// Requests hold their attributes until ack; memory read data is combinational.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              p0_req,   p1_req;
   logic              p0_we,    p1_we;
   logic [ADDR_W-1:0] p0_addr,  p1_addr;
   logic [1:0]        p0_size,  p1_size;
   logic [31:0]       p0_wdata, p1_wdata;
   logic              p0_ack,   p1_ack;
   logic              p0_err,   p1_err;
   logic [31:0]       p0_rdata, p1_rdata;

   logic [31:0]       data_addr;
   logic [31:0]       w_data_mem;
   logic              r_en_mem;
   logic              w_en_mem;
   logic [1:0]        byte_sel;
   logic [31:0]       r_data_mem;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_size, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_size, p1_wdata,
      output p0_ack, p0_err, p0_rdata,
      output p1_ack, p1_err, p1_rdata,
      output data_addr, w_data_mem, r_en_mem, w_en_mem, byte_sel,
      input  r_data_mem
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_size, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_size, p1_wdata,
      input  p0_ack, p0_err, p0_rdata,
      input  p1_ack, p1_err, p1_rdata,
      input  data_addr, w_data_mem, r_en_mem, w_en_mem, byte_sel,
      output r_data_mem
   );
endinterface

// File: rtl/dmem_req_check.sv
// Combinational legality check of one access: size code, natural alignment, memory bounds.
// Zero latency; purely combinational.
// No handshake; the caller decides what to do with a rejected access.
module dmem_req_check
   import dmem_arb_pkg::*;
#(
   parameter int DROM_SPACE = 1024,
   parameter int ADDR_W     = 32
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [1:0]        size_i,
   output logic              ok_o
);
   // One extra bit so addresses near the top of the space cannot wrap past the bound.
   localparam int AW1 = ADDR_W + 1;

   logic [AW1-1:0] last_byte;

   assign last_byte = {1'b0, addr_i} + AW1'(size_bytes(size_i)) - AW1'(1);

   // Any single failing rule rejects the access.
   always_comb begin
      ok_o = 1'b1;
      if (size_i == SZ_ILL)                           ok_o = 1'b0;
      if ((size_i == SZ_HALF) && addr_i[0])           ok_o = 1'b0;
      if ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00)) ok_o = 1'b0;
      if (last_byte >= AW1'(DROM_SPACE))              ok_o = 1'b0;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for data_memory: grant, check, single-cycle access, ack pulse.
// Latency: ack two cycles after the request is sampled in IDLE; one cycle for rejected requests.
// Backpressure: a requester holds req until its ack; macro DMEM_ARB_RR_EN selects round-robin on ties.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DROM_SPACE = 1024,
   parameter int ADDR_W     = 32
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);
   state_e            state_q;
   logic              last_q;
   logic              sel_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic [31:0]       wdata_q;
   logic [1:0]        ack_q;
   logic [1:0]        err_q;
   logic [31:0]       rdata0_q;
   logic [31:0]       rdata1_q;

   logic              sel_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [1:0]        size_d;
   logic [31:0]       wdata_d;
   logic              ok;
   logic [31:0]       rdata_mask;
   logic              in_access;

   // Pick the winning port (1 = port 1) among current requests.
   always_comb begin
      sel_d = 1'b0;
      if (bus.p0_req && bus.p1_req) begin
`ifdef DMEM_ARB_RR_EN
         sel_d = ~last_q;
`else
         sel_d = 1'b0;
`endif
      end else begin
         sel_d = bus.p1_req;
      end
   end

`ifndef DMEM_ARB_RR_EN
   // Fixed priority still tracks the last grant but never consults it.
   logic unused_last;
   assign unused_last = last_q;
`endif

   assign we_d    = sel_d ? bus.p1_we    : bus.p0_we;
   assign addr_d  = sel_d ? bus.p1_addr  : bus.p0_addr;
   assign size_d  = sel_d ? bus.p1_size  : bus.p0_size;
   assign wdata_d = sel_d ? bus.p1_wdata : bus.p0_wdata;

   dmem_req_check #(
      .DROM_SPACE (DROM_SPACE),
      .ADDR_W     (ADDR_W)
   ) u_check (
      .addr_i (addr_d),
      .size_i (size_d),
      .ok_o   (ok)
   );

   // Zero-extend load data to the latched access size.
   always_comb begin
      rdata_mask = bus.r_data_mem;
      case (size_q)
         SZ_BYTE: rdata_mask = {24'd0, bus.r_data_mem[7:0]};
         SZ_HALF: rdata_mask = {16'd0, bus.r_data_mem[15:0]};
         default: rdata_mask = bus.r_data_mem;
      endcase
   end

   // Memory command is the latched request, forced to zero outside ACCESS.
   assign in_access      = (state_q == ACCESS);
   assign bus.data_addr  = in_access ? 32'(addr_q) : 32'd0;
   assign bus.w_data_mem = in_access ? wdata_q     : 32'd0;
   assign bus.byte_sel   = in_access ? size_q      : 2'b00;
   assign bus.r_en_mem   = in_access & ~we_q;
   assign bus.w_en_mem   = in_access &  we_q;

   assign bus.p0_ack   = ack_q[0];
   assign bus.p1_ack   = ack_q[1];
   assign bus.p0_err   = err_q[0];
   assign bus.p1_err   = err_q[1];
   assign bus.p0_rdata = rdata0_q;
   assign bus.p1_rdata = rdata1_q;

   // Sequencer: grant and latch in IDLE, access memory once, then pulse the winner's response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         sel_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         size_q   <= SZ_BYTE;
         wdata_q  <= 32'd0;
         ack_q    <= 2'b00;
         err_q    <= 2'b00;
         rdata0_q <= 32'd0;
         rdata1_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.p0_req || bus.p1_req) begin
                  sel_q   <= sel_d;
                  last_q  <= sel_d;
                  we_q    <= we_d;
                  addr_q  <= addr_d;
                  size_q  <= size_d;
                  wdata_q <= wdata_d;
                  if (ok) begin
                     state_q <= ACCESS;
                  end else begin
                     state_q       <= DONE;
                     ack_q[sel_d]  <= 1'b1;
                     err_q[sel_d]  <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               state_q      <= DONE;
               ack_q[sel_q] <= 1'b1;
               if (!we_q) begin
                  if (sel_q) rdata1_q <= rdata_mask;
                  else       rdata0_q <= rdata_mask;
               end
            end
            DONE: begin
               state_q  <= IDLE;
               ack_q    <= 2'b00;
               err_q    <= 2'b00;
               rdata0_q <= 32'd0;
               rdata1_q <= 32'd0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
